// File: rtl/nco_poly_pkg.sv
// Shared types and helpers for the multi-voice NCO: waveform modes,
// engine states and the output saturation function.
package nco_poly_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Clamp a signed value to the two's-complement range of 'width' bits.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] val,
                                                  input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/nco_sine_rom.sv
// Full-wave sine ROM, contents computed at elaboration, registered read.
// Entries are trunc(SINE_AMP * sin(2*pi*k/2^LUT_AW)), truncated toward zero.
module nco_sine_rom #(
  parameter int LUT_AW   = 8,
  parameter int CODE_W   = 14,
  parameter int SINE_AMP = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LUT_AW-1:0]        addr,
  output logic signed [CODE_W-1:0] data
);

  localparam int  DEPTH = 1 << LUT_AW;
  localparam real PI    = 3.14159265358979323846;

  // Taylor series around zero after folding the angle into [-pi, pi]; a tiny
  // bias keeps exact peaks (e.g. sin(pi/2)) from truncating one LSB low.
  function automatic int rom_entry(input int k);
    real x;
    real term;
    real sum;
    real v;
    x = 2.0 * PI * $itor(k) / $itor(DEPTH);
    if (x > PI) begin
      x = x - 2.0 * PI;
    end else begin
      x = x;
    end
    term = x;
    sum  = x;
    for (int n = 1; n < 24; n++) begin
      term = -term * x * x / $itor((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    v = $itor(SINE_AMP) * sum;
    if (v >= 0.0) begin
      return $rtoi(v + 1.0e-9);
    end else begin
      return -$rtoi(-v + 1.0e-9);
    end
  endfunction

  logic signed [CODE_W-1:0] table_s [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int VAL = rom_entry(k);
    assign table_s[k] = CODE_W'(VAL);
  end

  // Synchronous ROM read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= {CODE_W{1'b0}};
    end else begin
      data <= table_s[addr];
    end
  end

endmodule

// File: rtl/nco_poly.sv
// Multi-voice NCO: NUM_VOICES phase accumulators served one per cycle by a
// shared engine (one sine ROM), mixed and saturated into one code per request.
module nco_poly
  import nco_poly_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24,
  parameter int LUT_AW     = 8,
  parameter int CODE_W     = 14,
  parameter int SINE_AMP   = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_VOICES*PHASE_W-1:0] fcw,
  input  logic [NUM_VOICES-1:0]         voice_en,
  input  logic [2*NUM_VOICES-1:0]       wave_sel,
  input  logic                          sync,
  input  logic                          next_sample,
  output logic [CODE_W-1:0]             code,
  output logic                          code_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int ACC_W  = CODE_W + $clog2(NUM_VOICES) + 1;
  localparam int SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [SLOT_W-1:0]        LAST_SLOT = SLOT_W'(NUM_VOICES - 1);
  localparam logic signed [LUT_AW:0]   HALF      = (LUT_AW + 1)'(1 << (LUT_AW - 1));
  localparam logic signed [LUT_AW+1:0] T_HALF    = (LUT_AW + 2)'(1 << (LUT_AW - 1));
  localparam logic signed [31:0]       AMP       = 32'(SINE_AMP);
  localparam logic signed [CODE_W-1:0] AMP_C     = CODE_W'(SINE_AMP);

  state_e                    state_r, state_next_s;
  logic [SLOT_W-1:0]         slot_r;
  logic [PHASE_W-1:0]        phase_r [NUM_VOICES];
  logic [PHASE_W-1:0]        fcw_s   [NUM_VOICES];
  wave_e                     wave_s  [NUM_VOICES];
  logic                      accept_s, step_s, finish_s, zero_s, overrun_s;
  logic [PHASE_W-1:0]        new_phase_s;
  logic [LUT_AW-1:0]         lut_addr_s;
  logic signed [LUT_AW:0]    s_s, mag_s;
  logic signed [LUT_AW+1:0]  tri_t_s;
  logic signed [31:0]        saw_p_s, tri_p_s;
  logic signed [CODE_W-1:0]  shaped_s, rom_q_s, pipe_shaped_r;
  logic                      pipe_valid_r, pipe_en_r, pipe_sine_r;
  logic signed [ACC_W-1:0]   acc_r, contrib_s, sum_s;
  logic signed [CODE_W-1:0]  code_next_s;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_unpack
    assign fcw_s[i]  = fcw[i*PHASE_W +: PHASE_W];
    assign wave_s[i] = wave_e'(wave_sel[2*i +: 2]);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  if (next_sample) state_next_s = ST_RUN; else state_next_s = ST_IDLE;
      ST_RUN:   if (slot_r == LAST_SLOT) state_next_s = ST_DRAIN; else state_next_s = ST_RUN;
      ST_DRAIN: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // FSM control strobes.
  always_comb begin
    accept_s  = 1'b0;
    step_s    = 1'b0;
    finish_s  = 1'b0;
    zero_s    = 1'b0;
    overrun_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        accept_s = next_sample;
        zero_s   = sync;
      end
      ST_RUN: begin
        step_s    = 1'b1;
        overrun_s = next_sample;
      end
      ST_DRAIN: begin
        finish_s  = 1'b1;
        overrun_s = next_sample;
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
  end

  // Phase advance for the voice in the current slot.
  always_comb begin
    if (voice_en[slot_r]) begin
      new_phase_s = phase_r[slot_r] + fcw_s[slot_r];
    end else begin
      new_phase_s = phase_r[slot_r];
    end
  end

  // Wave shaping of the non-sine modes from the freshly advanced phase.
  always_comb begin
    lut_addr_s = new_phase_s[PHASE_W-1 -: LUT_AW];
    s_s        = $signed({1'b0, lut_addr_s}) - HALF;
    if (s_s[LUT_AW]) begin
      mag_s = -s_s;
    end else begin
      mag_s = s_s;
    end
    tri_t_s = $signed({mag_s, 1'b0}) - T_HALF;
    saw_p_s = (32'(s_s) * AMP) >>> (LUT_AW - 1);
    tri_p_s = (32'(tri_t_s) * AMP) >>> (LUT_AW - 1);
    case (wave_s[slot_r])
      WAVE_SQUARE: begin
        if (new_phase_s[PHASE_W-1]) shaped_s = -AMP_C; else shaped_s = AMP_C;
      end
      WAVE_SAW: shaped_s = CODE_W'(saw_p_s);
      WAVE_TRI: begin
        if (tri_p_s > AMP) begin
          shaped_s = AMP_C;
        end else if (tri_p_s < -AMP) begin
          shaped_s = -AMP_C;
        end else begin
          shaped_s = CODE_W'(tri_p_s);
        end
      end
      default: shaped_s = {CODE_W{1'b0}};
    endcase
  end

  nco_sine_rom #(
    .LUT_AW  (LUT_AW),
    .CODE_W  (CODE_W),
    .SINE_AMP(SINE_AMP)
  ) u_rom (
    .clk (clk),
    .rst (rst),
    .addr(lut_addr_s),
    .data(rom_q_s)
  );

  // Phase accumulators: cleared by sync in IDLE, advanced one voice per RUN cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_VOICES; i++) phase_r[i] <= {PHASE_W{1'b0}};
    end else if (zero_s) begin
      for (int i = 0; i < NUM_VOICES; i++) phase_r[i] <= {PHASE_W{1'b0}};
    end else if (step_s) begin
      phase_r[slot_r] <= new_phase_s;
    end
  end

  // Slot counter and the one-stage pipe that lines shaped values up with the ROM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_r        <= {SLOT_W{1'b0}};
      pipe_valid_r  <= 1'b0;
      pipe_en_r     <= 1'b0;
      pipe_sine_r   <= 1'b0;
      pipe_shaped_r <= {CODE_W{1'b0}};
    end else begin
      if (accept_s) begin
        slot_r <= {SLOT_W{1'b0}};
      end else if (step_s) begin
        slot_r <= slot_r + SLOT_W'(1);
      end
      pipe_valid_r  <= step_s;
      pipe_en_r     <= voice_en[slot_r];
      pipe_sine_r   <= (wave_s[slot_r] == WAVE_SINE);
      pipe_shaped_r <= shaped_s;
    end
  end

  // Contribution of the voice processed in the previous cycle, and the mix sum.
  always_comb begin
    if (pipe_valid_r && pipe_en_r) begin
      if (pipe_sine_r) begin
        contrib_s = ACC_W'(rom_q_s);
      end else begin
        contrib_s = ACC_W'(pipe_shaped_r);
      end
    end else begin
      contrib_s = {ACC_W{1'b0}};
    end
    sum_s       = acc_r + contrib_s;
    code_next_s = CODE_W'(saturate(32'(sum_s), CODE_W));
  end

  // Mix accumulator, cleared at the start of each request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (accept_s) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (step_s) begin
      acc_r <= sum_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code       <= {CODE_W{1'b0}};
      code_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (finish_s) code <= code_next_s;
      code_valid <= finish_s;
      busy       <= (state_next_s != ST_IDLE);
      overrun    <= overrun_s;
    end
  end

endmodule
